// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_R,
        OP_I,
        OP_LOAD,
        OP_S,
        OP_SB,
        OP_UJ,
        OP_JALR,
        OP_U,
        OP_ILL
    } op_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_SB   = 7'b1100011;
    localparam logic [6:0] OPC_UJ   = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_U    = 7'b0110111;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_SB   = 3'd2;
    localparam logic [2:0] IMM_UJ   = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JAL   = 2'd2;
    localparam logic [1:0] PC_JALR  = 2'd3;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] WB_IMM   = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// Opcode classifier: maps instr[6:0] to an instruction class and
// the per-class datapath selects (immediate format, ALU B, write-back).
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_t        o_op,
    output logic [2:0] o_imm_type,
    output logic       o_alu_src_b,
    output logic [1:0] o_wb_sel
);

    always_comb begin
        o_op = OP_ILL;
        unique case (1'b1)
            (i_opcode == OPC_R):    o_op = OP_R;
            (i_opcode == OPC_I):    o_op = OP_I;
            (i_opcode == OPC_LOAD): o_op = OP_LOAD;
            (i_opcode == OPC_S):    o_op = OP_S;
            (i_opcode == OPC_SB):   o_op = OP_SB;
            (i_opcode == OPC_UJ):   o_op = OP_UJ;
            (i_opcode == OPC_JALR): o_op = OP_JALR;
            (i_opcode == OPC_U):    o_op = OP_U;
            default:                o_op = OP_ILL;
        endcase
    end

    always_comb begin
        o_imm_type  = IMM_NONE;
        o_alu_src_b = 1'b1;
        o_wb_sel    = WB_ALU;
        case (o_op)
            OP_R: begin
                o_alu_src_b = 1'b0;
            end
            OP_I: begin
                o_imm_type = IMM_I;
            end
            OP_LOAD: begin
                o_imm_type = IMM_I;
                o_wb_sel   = WB_MEM;
            end
            OP_S: begin
                o_imm_type = IMM_S;
            end
            OP_SB: begin
                o_imm_type  = IMM_SB;
                o_alu_src_b = 1'b0;
            end
            OP_UJ: begin
                o_imm_type = IMM_UJ;
                o_wb_sel   = WB_PC4;
            end
            OP_JALR: begin
                o_imm_type = IMM_I;
                o_wb_sel   = WB_PC4;
            end
            OP_U: begin
                o_imm_type = IMM_U;
                o_wb_sel   = WB_IMM;
            end
            default: begin
                o_imm_type = IMM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32 control FSM: sequences fetch/decode/exec/mem/wb,
// drives datapath strobes and counts retired instructions.
module mc_control
    import mc_pkg::*;
#(
    parameter int RET_W = 32
)
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       imm_type,
    output logic             alu_src_b,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [RET_W-1:0] instret
);

    state_t           r_state;
    logic             r_live;
    logic             r_illegal;
    logic [RET_W-1:0] r_instret;

    op_t        w_op;
    logic [2:0] w_imm;
    logic       w_alu_b;
    logic [1:0] w_wb;
    logic       w_on;
    logic       w_unused;

    mc_decode u_decode (
        .i_opcode    (instr[6:0]),
        .o_op        (w_op),
        .o_imm_type  (w_imm),
        .o_alu_src_b (w_alu_b),
        .o_wb_sel    (w_wb)
    );

    assign w_unused = ^instr[31:7];

    // Strobes stay low while reset is applied and for the first cycle after.
    assign w_on = n_rst & r_live;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        imm_type  = IMM_NONE;
        alu_src_b = w_alu_b;
        wb_sel    = w_wb;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = w_on & mem_ready;
            end
            ST_DECODE: begin
                imm_type = w_imm;
            end
            ST_EXEC: begin
                imm_type = w_imm;
                if (w_op == OP_SB) begin
                    pc_we  = w_on;
                    pc_sel = br_taken ? PC_BR : PC_PLUS4;
                end
            end
            ST_MEM: begin
                imm_type = w_imm;
                mem_req  = 1'b1;
                mem_we   = (w_op == OP_S);
                if (w_op == OP_S) begin
                    pc_we = w_on & mem_ready;
                end
            end
            ST_WB: begin
                imm_type = w_imm;
                reg_we   = w_on;
                pc_we    = w_on;
                if (w_op == OP_UJ) begin
                    pc_sel = PC_JAL;
                end else if (w_op == OP_JALR) begin
                    pc_sel = PC_JALR;
                end
            end
            default: begin
                imm_type = IMM_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= ST_FETCH;
            r_live    <= 1'b0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_live <= 1'b1;
            if (pc_we) begin
                r_instret <= r_instret + {{(RET_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                ST_FETCH: begin
                    if (r_live && mem_ready) begin
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_op == OP_ILL) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_op)
                        OP_LOAD, OP_S: r_state <= ST_MEM;
                        OP_SB:         r_state <= ST_FETCH;
                        default:       r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_state <= (w_op == OP_S) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed and randomized
// instructions checked against a per-class timing/select table.
module tb_mc_control;

    logic        clk;
    logic        n_rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        reg_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_type;
    logic        alu_src_b;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [31:0] instret;

    int          n_tests;
    int          n_fail;
    logic [31:0] m_ret;

    mc_control #(.RET_W(32)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .instr     (instr),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .imm_type  (imm_type),
        .alu_src_b (alu_src_b),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference table: cycles, memory phase and selects per opcode class.
    task automatic model(input logic [6:0] opc, input bit br,
                         output int base, output bit is_mem,
                         output bit is_st, output int e_reg,
                         output logic [1:0] e_pcs, output logic [1:0] e_wb,
                         output logic [2:0] e_imm, output logic e_alub);
        base = 4; is_mem = 0; is_st = 0; e_reg = 1;
        e_pcs = 2'd0; e_wb = 2'd0; e_imm = 3'd7; e_alub = 1'b1;
        case (opc)
            7'b0110011: e_alub = 1'b0;
            7'b0010011: e_imm = 3'd0;
            7'b0000011: begin
                base = 5; is_mem = 1; e_imm = 3'd0; e_wb = 2'd1;
            end
            7'b0100011: begin
                is_mem = 1; is_st = 1; e_reg = 0; e_imm = 3'd1;
            end
            7'b1100011: begin
                base = 3; e_reg = 0; e_imm = 3'd2; e_alub = 1'b0;
                e_pcs = br ? 2'd1 : 2'd0;
            end
            7'b1101111: begin e_imm = 3'd3; e_wb = 2'd2; e_pcs = 2'd2; end
            7'b1100111: begin e_imm = 3'd0; e_wb = 2'd2; e_pcs = 2'd3; end
            7'b0110111: begin e_imm = 3'd4; e_wb = 2'd3; end
            default: ;
        endcase
    endtask

    // Runs one instruction from a live FETCH cycle; wf/wm are wait cycles.
    task automatic run_instr(input logic [31:0] ins, input bit br,
                             input int wf, input int wm, input string tag);
        int base, e_reg, ms;
        bit is_mem, is_st;
        logic [1:0] e_pcs, e_wb, o_pcs, o_wb;
        logic [2:0] e_imm, o_imm;
        logic e_alub, o_alub;
        int ir_at, ir_cnt, reg_cnt, pc_at, req_cnt, we_cnt;
        model(ins[6:0], br, base, is_mem, is_st, e_reg,
              e_pcs, e_wb, e_imm, e_alub);
        ir_at = -1; ir_cnt = 0; reg_cnt = 0; pc_at = -1;
        req_cnt = 0; we_cnt = 0; ms = wf + 3;
        o_pcs = 'x; o_wb = 'x; o_imm = 'x; o_alub = 'x;
        for (int k = 0; k < 60 && pc_at < 0; k++) begin
            @(negedge clk);
            instr = ins;
            br_taken = br;
            if (k <= wf)
                mem_ready = (k == wf);
            else if (is_mem && k >= ms && k <= ms + wm)
                mem_ready = (k == ms + wm);
            else
                mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (k == 0) chk({tag, " instret_pre"}, instret, m_ret);
            if (ir_we) begin ir_at = k; ir_cnt++; end
            reg_cnt += int'(reg_we);
            req_cnt += int'(mem_req);
            we_cnt  += int'(mem_req & mem_we);
            if (reg_we) o_wb = wb_sel;
            if (pc_we) begin
                pc_at = k; o_pcs = pc_sel; o_imm = imm_type; o_alub = alu_src_b;
            end
        end
        m_ret = m_ret + 32'd1;
        chk({tag, " cycles"}, pc_at + 1, base + wf + (is_mem ? wm : 0));
        chk({tag, " ir_we_at"}, ir_at, wf);
        chk({tag, " ir_we_cnt"}, ir_cnt, 1);
        chk({tag, " reg_we_cnt"}, reg_cnt, e_reg);
        chk({tag, " mem_req_cyc"}, req_cnt, wf + 1 + (is_mem ? wm + 1 : 0));
        chk({tag, " mem_we_cyc"}, we_cnt, is_st ? wm + 1 : 0);
        chk({tag, " pc_sel"}, o_pcs, e_pcs);
        chk({tag, " imm_type"}, o_imm, e_imm);
        chk({tag, " alu_src_b"}, o_alub, e_alub);
        if (e_reg == 1) chk({tag, " wb_sel"}, o_wb, e_wb);
    endtask

    task automatic do_reset(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            n_rst = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst_strobes", {ir_we, reg_we, pc_we}, 3'b000);
        end
        @(negedge clk);
        n_rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("post_rst_strobes", {ir_we, reg_we, pc_we}, 3'b000);
        chk("post_rst_mem_req", mem_req, 1'b1);
        chk("post_rst_instret", instret, 32'd0);
        chk("post_rst_illegal", illegal, 1'b0);
        m_ret = '0;
    endtask

    logic [6:0] opcs [8];

    initial begin
        n_tests = 0; n_fail = 0; m_ret = '0;
        n_rst = 1'b0; instr = 32'h0000_0013; mem_ready = 1'b0; br_taken = 1'b0;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

        do_reset(2);
        run_instr(32'h0050_0093, 1'b0, 0, 0, "addi");
        run_instr(32'h0000_2083, 1'b0, 0, 3, "lw_wait");
        run_instr(32'h0020_8463, 1'b1, 0, 0, "beq_t");
        run_instr(32'h0020_8463, 1'b0, 1, 0, "beq_nt");
        run_instr(32'h0011_2023, 1'b0, 2, 1, "sw");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = opcs[$urandom_range(0, 7)];
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), "rand");
        end

        // Reset while a store waits in MEM.
        run_instr(32'h0050_0093, 1'b0, 0, 0, "addi_pre");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            instr = 32'h0011_2023;
            mem_ready = (k == 0);
        end
        #1;
        chk("sw_mem_req", {mem_req, mem_we}, 2'b11);
        chk("sw_mem_pc_we", pc_we, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("sw_rst_pc_we", pc_we, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("sw_rst_instret", instret, 32'd0);
        chk("sw_rst_fetch", {mem_req, mem_we, ir_we}, 3'b100);
        m_ret = '0;
        run_instr(32'h0050_0093, 1'b0, 0, 0, "addi_after_rst");

        // Counter wrap on a retiring jal.
        @(negedge clk);
        mem_ready = 1'b0;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        m_ret = 32'hFFFF_FFFF;
        run_instr(32'h0080_006F, 1'b0, 0, 0, "jal_wrap");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("wrap_instret", instret, m_ret);

        // Illegal opcode traps and stays trapped.
        do_reset(1);
        @(negedge clk);
        instr = 32'h0000_007F;
        mem_ready = 1'b1;
        #1;
        chk("trap_fetch_ir_we", ir_we, 1'b1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("trap_decode_illegal", illegal, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            br_taken = 1'($urandom_range(0, 1));
            #1;
            chk("trap_illegal", illegal, 1'b1);
            chk("trap_outputs", {ir_we, reg_we, pc_we, mem_req}, 4'b0000);
            chk("trap_instret", instret, m_ret);
        end

        do_reset(1);
        chk("rst_clears_illegal", illegal, 1'b0);
        run_instr(32'h1234_50B7, 1'b0, 0, 0, "lui");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("final_instret", instret, m_ret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter RET_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 instr  input  32  current instruction-register contents.
REQ-005 mem_ready  input  1  memory handshake; current request completes this cycle.
REQ-006 br_taken  input  1  branch comparison result from ALU, valid in EXEC.
REQ-007 mem_req  output  1  memory request; held high until mem_ready.
REQ-008 mem_we  output  1  memory write qualifier, valid with mem_req.
REQ-009 ir_we  output  1  instruction-register load strobe.
REQ-010 reg_we  output  1  register-file write strobe.
REQ-011 pc_we  output  1  PC update strobe.
REQ-012 pc_sel  output  2  next-PC source: 0 PC+4, 1 branch target, 2 JAL target, 3 JALR target.
REQ-013 imm_type  output  3  immediate format to immediate generator: 0 I, 1 S, 2 SB, 3 UJ, 4 U, 7 none.
REQ-014 alu_src_b  output  1  0 register rs2, 1 immediate.
REQ-015 wb_sel  output  2  write-back source: 0 ALU, 1 memory data, 2 PC+4, 3 immediate.
REQ-016 illegal  output  1  sticky illegal-opcode flag.
REQ-017 instret  output  RET_W  retired-instruction count.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; strobes are decoded from state and instr[6:0] only, except where mem_ready or br_taken is stated.
REQ-019 FETCH: mem_req=1, mem_we=0; ir_we=mem_ready; advance to DECODE on mem_ready, else remain.
REQ-020 DECODE: one cycle; opcodes 0110011 (R), 0010011 (I), 0000011 (LOAD), 0100011 (S), 1100011 (SB), 1101111 (UJ), 1100111 (JALR), 0110111 (U) -> EXEC; any other opcode -> TRAP.
REQ-021 imm_type SHALL be driven from DECODE through WB per opcode: I/LOAD/JALR->I, S->S, SB->SB, UJ->UJ, U->U, R->none; 7 in FETCH and TRAP.
REQ-022 alu_src_b SHALL be 0 for R and SB, 1 otherwise.
REQ-023 EXEC: R, I, U, UJ, JALR -> WB; LOAD, S -> MEM; SB -> pc_we=1, pc_sel=1 if br_taken else 0, -> FETCH.
REQ-024 MEM: mem_req=1, mem_we=1 for S and 0 for LOAD; wait for mem_ready; on mem_ready: LOAD -> WB; S -> pc_we=1, pc_sel=0, -> FETCH.
REQ-025 WB: reg_we=1 for one cycle, pc_we=1; wb_sel 0 (R/I), 1 (LOAD), 2 (UJ/JALR), 3 (U); pc_sel 2 for UJ, 3 for JALR, else 0; -> FETCH.
REQ-026 reg_we, pc_we, ir_we SHALL each be high for exactly one cycle per instruction.
REQ-027 instret SHALL increment by 1 in every cycle pc_we=1, wrapping from all-ones to 0.
REQ-028 TRAP: illegal=1, no strobes, mem_req=0; state held until reset.
REQ-029 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-030 Cycle count per instruction with zero-wait memory: R/I/U/UJ/JALR 4, SB 3, S 4, LOAD 5.

Reset
REQ-031 On n_rst=0 at a clock edge: state=FETCH, instret=0, illegal=0; reset mid-transaction SHALL abandon it without a strobe.
REQ-032 During and one cycle after reset deassertion, ir_we, reg_we, pc_we SHALL be 0; mem_req asserts from the first FETCH cycle.

Structure
REQ-033 A shared package SHALL hold the state enum, opcode constants, imm_type, pc_sel and wb_sel encodings.
REQ-034 Opcode classification SHALL be one combinational sub-module, mc_decode; FSM and counter stay in mc_control.

Verification
REQ-035 instr=0x00500093 (addi), mem_ready=1 -> FETCH,DECODE,EXEC,WB; reg_we and pc_we in cycle 4, wb_sel=0, imm_type=0, instret 0->1.
REQ-036 instr=0x00002083 (lw), mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, then WB with wb_sel=1; total 8 cycles.
REQ-037 instr=0x00208463 (beq), br_taken=1 -> pc_we in EXEC, pc_sel=1, no reg_we; br_taken=0 -> pc_sel=0.
REQ-038 instr=0x0000007F -> TRAP after DECODE, illegal=1 stays set for 20 cycles, no strobes, instret unchanged.
REQ-039 n_rst=0 during MEM of sw (0x00112023) with mem_ready=0 -> next state FETCH, no pc_we, instret=0.
REQ-040 Preload instret to 0xFFFFFFFF by forcing, retire jal (0x0080006F) -> instret=0, pc_sel=2, wb_sel=2.
